// File: rtl/regfile_dump_reader.sv
// Walks every register through one read port and streams {address, data} beats to a sink.
// Optional macro REGDUMP_CHECKSUM_EN appends an XOR checksum beat after the last register.
module regfile_dump_reader #(
   parameter int DATA_WIDTH    = 8,
   parameter int NUM_REGISTERS = 4,
   parameter int ADDR_WIDTH    = 2,
   parameter int READ_LATENCY  = 0
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic                  abort,
   output logic [ADDR_WIDTH-1:0] rd_addr,
   input  logic [DATA_WIDTH-1:0] rd_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [ADDR_WIDTH-1:0] out_addr,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic                  out_last,
   output logic                  out_csum,
   output logic                  busy,
   output logic                  done
);

`ifdef REGDUMP_CHECKSUM_EN
   localparam bit CSUM_EN = 1'b1;
`else
   localparam bit CSUM_EN = 1'b0;
`endif

   localparam logic [ADDR_WIDTH-1:0] LAST_INDEX = ADDR_WIDTH'(NUM_REGISTERS - 1);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      ISSUE   = 3'd1,
      WAIT    = 3'd2,
      PRESENT = 3'd3,
      FINISH  = 3'd4
   } state_t;

   state_t                state_r;
   logic [ADDR_WIDTH-1:0] index_r;
   logic [DATA_WIDTH-1:0] csum_acc_r;

   // Dump sequencer: all outputs are registered; abort from any busy state returns to IDLE
   always_ff @(posedge clk) begin
      if (reset || (abort && state_r != IDLE)) begin
         state_r    <= IDLE;
         index_r    <= '0;
         csum_acc_r <= '0;
         rd_addr    <= '0;
         out_valid  <= 1'b0;
         out_addr   <= '0;
         out_data   <= '0;
         out_last   <= 1'b0;
         out_csum   <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               rd_addr <= '0;
               done    <= 1'b0;
               if (start) begin
                  state_r    <= ISSUE;
                  index_r    <= '0;
                  csum_acc_r <= '0;
                  busy       <= 1'b1;
               end
            end
            ISSUE, WAIT: begin
               if (state_r == ISSUE && READ_LATENCY == 1) begin
                  state_r <= WAIT;
               end else begin
                  // Capture register keeps the beat stable even if the file is written while stalled
                  state_r   <= PRESENT;
                  out_valid <= 1'b1;
                  out_addr  <= index_r;
                  out_data  <= rd_data;
                  out_last  <= !CSUM_EN && (index_r == LAST_INDEX);
                  out_csum  <= 1'b0;
               end
            end
            PRESENT: begin
               if (out_ready) begin
                  if (out_csum || (!CSUM_EN && index_r == LAST_INDEX)) begin
                     state_r   <= FINISH;
                     out_valid <= 1'b0;
                     out_last  <= 1'b0;
                     out_csum  <= 1'b0;
                     rd_addr   <= '0;
                     done      <= 1'b1;
                  end else if (index_r == LAST_INDEX) begin
                     // Checksum beat follows the last register beat back to back
                     out_csum   <= 1'b1;
                     out_addr   <= '0;
                     out_data   <= csum_acc_r ^ out_data;
                     out_last   <= 1'b1;
                     csum_acc_r <= csum_acc_r ^ out_data;
                  end else begin
                     state_r   <= ISSUE;
                     out_valid <= 1'b0;
                     index_r   <= index_r + ADDR_WIDTH'(1);
                     rd_addr   <= index_r + ADDR_WIDTH'(1);
                     if (CSUM_EN) begin
                        csum_acc_r <= csum_acc_r ^ out_data;
                     end
                  end
               end
            end
            FINISH: begin
               state_r    <= IDLE;
               done       <= 1'b0;
               busy       <= 1'b0;
               index_r    <= '0;
               csum_acc_r <= '0;
               rd_addr    <= '0;
            end
            default: begin
               state_r    <= IDLE;
               index_r    <= '0;
               csum_acc_r <= '0;
               rd_addr    <= '0;
               out_valid  <= 1'b0;
               out_last   <= 1'b0;
               out_csum   <= 1'b0;
               busy       <= 1'b0;
               done       <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_regfile_dump_reader.sv
// Directed bench: instance 0 sees a combinational-read register file, instance 1 a registered-read one.
module tb_regfile_dump_reader;
   localparam int DW = 8;
   localparam int NR = 4;
   localparam int AW = 2;
`ifdef REGDUMP_CHECKSUM_EN
   localparam int NB = 5;
`else
   localparam int NB = 4;
`endif

   logic          clk = 1'b0;
   logic          reset;
   logic [1:0]    start_s;
   logic [1:0]    abort_s;
   logic [1:0]    ready_s;
   logic [AW-1:0] rd_addr_s [2];
   logic [DW-1:0] rd_data0;
   logic [DW-1:0] rd_data1;
   logic          valid_s [2];
   logic [AW-1:0] addr_s [2];
   logic [DW-1:0] data_s [2];
   logic          last_s [2];
   logic          csum_s [2];
   logic          busy_s [2];
   logic          done_s [2];
   logic [DW-1:0] regs [NR];
   int            n_checks = 0;
   int            n_errors = 0;

   always #5 clk = ~clk;

   assign rd_data0 = regs[rd_addr_s[0]];

   // Registered-read register file model for the latency-1 instance
   always_ff @(posedge clk) begin
      rd_data1 <= regs[rd_addr_s[1]];
   end

   regfile_dump_reader #(.DATA_WIDTH(DW), .NUM_REGISTERS(NR), .ADDR_WIDTH(AW), .READ_LATENCY(0)) u0 (
      .clk(clk), .reset(reset), .start(start_s[0]), .abort(abort_s[0]),
      .rd_addr(rd_addr_s[0]), .rd_data(rd_data0),
      .out_valid(valid_s[0]), .out_ready(ready_s[0]), .out_addr(addr_s[0]), .out_data(data_s[0]),
      .out_last(last_s[0]), .out_csum(csum_s[0]), .busy(busy_s[0]), .done(done_s[0])
   );

   regfile_dump_reader #(.DATA_WIDTH(DW), .NUM_REGISTERS(NR), .ADDR_WIDTH(AW), .READ_LATENCY(1)) u1 (
      .clk(clk), .reset(reset), .start(start_s[1]), .abort(abort_s[1]),
      .rd_addr(rd_addr_s[1]), .rd_data(rd_data1),
      .out_valid(valid_s[1]), .out_ready(ready_s[1]), .out_addr(addr_s[1]), .out_data(data_s[1]),
      .out_last(last_s[1]), .out_csum(csum_s[1]), .busy(busy_s[1]), .done(done_s[1])
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic check_idle_zero(input int u, input string tag);
      check({tag, " rd_addr"}, 32'(rd_addr_s[u]), 32'd0);
      check({tag, " valid"},   32'(valid_s[u]),   32'd0);
      check({tag, " addr"},    32'(addr_s[u]),    32'd0);
      check({tag, " data"},    32'(data_s[u]),    32'd0);
      check({tag, " last"},    32'(last_s[u]),    32'd0);
      check({tag, " csum"},    32'(csum_s[u]),    32'd0);
      check({tag, " busy"},    32'(busy_s[u]),    32'd0);
      check({tag, " done"},    32'(done_s[u]),    32'd0);
   endtask

   // Full dump with out_ready high; checks latency, beat spacing, beat contents and the done pulse
   task automatic run_dump(input int u, input int lat_exp, input int gap_exp,
                           input logic [DW-1:0] d0, input logic [DW-1:0] d1,
                           input logic [DW-1:0] d2, input logic [DW-1:0] d3,
                           input logic [DW-1:0] csum_exp, input string tag);
      logic [DW-1:0] dv [4];
      int n;
      dv[0] = d0; dv[1] = d1; dv[2] = d2; dv[3] = d3;
      ready_s[u] = 1'b1;
      start_s[u] = 1'b1;
      n = 0;
      do begin
         @(posedge clk); #1;
         start_s[u] = 1'b0;
         n++;
      end while (!valid_s[u] && n < 20);
      check({tag, " latency"}, 32'(n), 32'(lat_exp));
      for (int b = 0; b < NB; b++) begin
         if (b > 0) begin
            n = 0;
            do begin
               @(posedge clk); #1;
               n++;
            end while (!valid_s[u] && n < 20);
            check($sformatf("%s b%0d gap", tag, b), 32'(n), (b == 4) ? 32'd1 : 32'(gap_exp));
         end
         check($sformatf("%s b%0d valid", tag, b), 32'(valid_s[u]), 32'd1);
         check($sformatf("%s b%0d addr", tag, b), 32'(addr_s[u]), (b < 4) ? 32'(b) : 32'd0);
         check($sformatf("%s b%0d data", tag, b), 32'(data_s[u]), (b < 4) ? 32'(dv[b]) : 32'(csum_exp));
         check($sformatf("%s b%0d last", tag, b), 32'(last_s[u]), (b == NB - 1) ? 32'd1 : 32'd0);
         check($sformatf("%s b%0d csum", tag, b), 32'(csum_s[u]), (b == 4) ? 32'd1 : 32'd0);
      end
      @(posedge clk); #1;
      check({tag, " done pulse"}, 32'(done_s[u]), 32'd1);
      check({tag, " finish busy"}, 32'(busy_s[u]), 32'd1);
      check({tag, " finish rd_addr"}, 32'(rd_addr_s[u]), 32'd0);
      check({tag, " finish valid"}, 32'(valid_s[u]), 32'd0);
      start_s[u] = 1'b1;
      @(posedge clk); #1;
      start_s[u] = 1'b0;
      check({tag, " done end"}, 32'(done_s[u]), 32'd0);
      check({tag, " idle busy"}, 32'(busy_s[u]), 32'd0);
      @(posedge clk); #1;
      check({tag, " finish start ignored"}, 32'(busy_s[u]), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int n;
      regs    = '{8'h11, 8'h22, 8'h33, 8'h44};
      reset   = 1'b1;
      start_s = 2'b00;
      abort_s = 2'b00;
      ready_s = 2'b11;
      repeat (3) @(posedge clk);
      #1;
      check_idle_zero(0, "reset u0");
      check_idle_zero(1, "reset u1");
      reset = 1'b0;
      @(posedge clk); #1;

      run_dump(0, 2, 2, 8'h11, 8'h22, 8'h33, 8'h44, 8'h44, "rl0");
      run_dump(1, 3, 3, 8'h11, 8'h22, 8'h33, 8'h44, 8'h44, "rl1");

      // Stall beat 1 while the register behind it is rewritten; start while busy is ignored
      start_s[0] = 1'b1;
      @(posedge clk); #1;
      start_s[0] = 1'b0;
      @(posedge clk); #1;
      check("stall b0 addr", 32'(addr_s[0]), 32'd0);
      @(posedge clk); #1;
      ready_s[0] = 1'b0;
      @(posedge clk); #1;
      regs[1]    = 8'hAA;
      start_s[0] = 1'b1;
      for (int i = 0; i < 5; i++) begin
         check($sformatf("stall c%0d valid", i), 32'(valid_s[0]), 32'd1);
         check($sformatf("stall c%0d addr", i), 32'(addr_s[0]), 32'd1);
         check($sformatf("stall c%0d data", i), 32'(data_s[0]), 32'h22);
         @(posedge clk); #1;
      end
      check("stall held data", 32'(data_s[0]), 32'h22);
      start_s[0] = 1'b0;
      ready_s[0] = 1'b1;
      @(posedge clk); #1;
      check("stall release valid", 32'(valid_s[0]), 32'd0);
      n = 0;
      while (!done_s[0] && n < 30) begin
         @(posedge clk); #1;
         n++;
      end
      check("stall dump done", 32'(done_s[0]), 32'd1);
      @(posedge clk); #1;
      run_dump(0, 2, 2, 8'h11, 8'hAA, 8'h33, 8'h44, 8'hCC, "rl0 rewritten");

      // Abort while beat 2 is presented, with out_ready high in the same cycle
      start_s[0] = 1'b1;
      @(posedge clk); #1;
      start_s[0] = 1'b0;
      n = 0;
      while (!(valid_s[0] && addr_s[0] == 2'd2) && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      check("abort at beat2 valid", 32'(valid_s[0]), 32'd1);
      check("abort at beat2 addr", 32'(addr_s[0]), 32'd2);
      abort_s[0] = 1'b1;
      @(posedge clk); #1;
      abort_s[0] = 1'b0;
      check("abort valid", 32'(valid_s[0]), 32'd0);
      check("abort busy", 32'(busy_s[0]), 32'd0);
      check("abort done", 32'(done_s[0]), 32'd0);
      @(posedge clk); #1;
      check("abort no done", 32'(done_s[0]), 32'd0);
      run_dump(0, 2, 2, 8'h11, 8'hAA, 8'h33, 8'h44, 8'hCC, "rl0 after abort");

      // Reset while the latency-1 instance waits on register 2
      start_s[1] = 1'b1;
      @(posedge clk); #1;
      start_s[1] = 1'b0;
      n = 0;
      while (!(valid_s[1] && addr_s[1] == 2'd1) && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      check("pre-reset beat1 data", 32'(data_s[1]), 32'hAA);
      @(posedge clk); #1;
      @(posedge clk); #1;
      check("wait rd_addr", 32'(rd_addr_s[1]), 32'd2);
      check("wait busy", 32'(busy_s[1]), 32'd1);
      check("wait valid", 32'(valid_s[1]), 32'd0);
      reset = 1'b1;
      @(posedge clk); #1;
      check_idle_zero(1, "mid-wait reset");
      reset = 1'b0;
      @(posedge clk); #1;
      run_dump(1, 3, 3, 8'h11, 8'hAA, 8'h33, 8'h44, 8'hCC, "rl1 after reset");

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
